// File: rtl/hpdmc_datactl_gen_if.sv
// Command/status bundle between the HPDMC command FSM and the data-path timing controller.
// The master side issues commands and timings; the slave side reports safety and DQ direction.
interface hpdmc_datactl_gen_if #(
    parameter int unsigned NBANKS = 4
);
    logic              read;
    logic              write;
    logic [NBANKS-1:0] concerned_bank;
    logic [2:0]        tim_cl;
    logic [1:0]        tim_wtr;
    logic [1:0]        tim_wr;
    logic              err_clr;

    logic              read_safe;
    logic              write_safe;
    logic [NBANKS-1:0] precharge_safe;
    logic              direction;
    logic              direction_r;
    logic              idle;
    logic              proto_err;

    modport master (
        output read, write, concerned_bank, tim_cl, tim_wtr, tim_wr, err_clr,
        input  read_safe, write_safe, precharge_safe, direction, direction_r, idle, proto_err
    );

    modport slave (
        input  read, write, concerned_bank, tim_cl, tim_wtr, tim_wr, err_clr,
        output read_safe, write_safe, precharge_safe, direction, direction_r, idle, proto_err
    );
endinterface

// File: rtl/hpdmc_datactl_gen.sv
// Data-path timing controller for the HPDMC scheduler: read/write turnaround, per-bank
// precharge hold-off, DQ direction window and sticky protocol-violation detection.
module hpdmc_datactl_gen #(
    parameter int unsigned NBANKS    = 4,
    parameter int unsigned BURST_CYC = 4
) (
    input  logic               sys_clk,
    input  logic               sdram_rst_n,
    hpdmc_datactl_gen_if.slave dc
);
    localparam int unsigned CW = $clog2(BURST_CYC + 9);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t L_BURST = cnt_t'(BURST_CYC);
    localparam cnt_t L_DIR   = cnt_t'(BURST_CYC + 1);

    // Counts down toward zero; a load never shortens the hold-off still remaining.
    function automatic cnt_t reload(input cnt_t q, input logic load, input cnt_t l);
        cnt_t rem;
        rem = (q == '0) ? '0 : q - cnt_t'(1);
        return (load && (l > rem)) ? l : rem;
    endfunction

    cnt_t              rd_q, rd_d;
    cnt_t              wr_q, wr_d;
    cnt_t              dw_q, dw_d;
    cnt_t              pc_q [NBANKS];
    cnt_t              pc_d [NBANKS];
    cnt_t              rd_l, wr_l, pc_l;
    logic [NBANKS-1:0] pc_zero_d;
    logic              cmd, wr_only, err_set, err_d;

    logic              rd_safe_q, wr_safe_q;
    logic [NBANKS-1:0] pc_safe_q;
    logic              dir0_q, dir1_q, dir_q, dir_r_q;
    logic              err_q;

    always_comb begin
        cmd     = dc.read | dc.write;
        wr_only = dc.write & ~dc.read;

        // Read wins every load when both commands arrive together.
        rd_l = dc.read ? L_BURST : L_BURST + cnt_t'(1) + cnt_t'(dc.tim_wtr);
        wr_l = dc.read ? L_BURST + cnt_t'(1) + cnt_t'(dc.tim_cl) : L_BURST;
        pc_l = dc.read ? L_BURST : L_BURST + cnt_t'(2) + cnt_t'(dc.tim_wr);

        rd_d = reload(rd_q, cmd, rd_l);
        wr_d = reload(wr_q, cmd, wr_l);
        dw_d = reload(dw_q, wr_only, L_DIR);

        pc_zero_d = '0;
        for (int unsigned i = 0; i < NBANKS; i++) begin
            pc_d[i]      = reload(pc_q[i], cmd & dc.concerned_bank[i], pc_l);
            pc_zero_d[i] = (pc_d[i] == '0);
        end

        err_set = (dc.read & ~rd_safe_q) | (dc.write & ~wr_safe_q) | (dc.read & dc.write);
        err_d   = err_set | (err_q & ~dc.err_clr);
    end

    always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            rd_q      <= '0;
            wr_q      <= '0;
            dw_q      <= '0;
            for (int unsigned i = 0; i < NBANKS; i++) pc_q[i] <= '0;
            rd_safe_q <= 1'b1;
            wr_safe_q <= 1'b1;
            pc_safe_q <= '1;
            dir0_q    <= 1'b1;
            dir1_q    <= 1'b1;
            dir_q     <= 1'b1;
            dir_r_q   <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            dw_q      <= dw_d;
            for (int unsigned i = 0; i < NBANKS; i++) pc_q[i] <= pc_d[i];
            rd_safe_q <= (rd_d == '0);
            wr_safe_q <= (wr_d == '0);
            pc_safe_q <= pc_zero_d;
            // Extra stage places the turnaround window two edges after the write.
            dir0_q    <= ~(dc.write | (dw_q != '0));
            dir1_q    <= dir0_q;
            dir_q     <= dir1_q;
            dir_r_q   <= dir_q;
            err_q     <= err_d;
        end
    end

    assign dc.read_safe      = rd_safe_q;
    assign dc.write_safe     = wr_safe_q;
    assign dc.precharge_safe = pc_safe_q;
    assign dc.direction      = dir_q;
    assign dc.direction_r    = dir_r_q;
    assign dc.proto_err      = err_q;
    assign dc.idle           = rd_safe_q & wr_safe_q & (&pc_safe_q) & dir_q;
endmodule

// File: tb/tb_hpdmc_datactl_gen.sv
// Bench for hpdmc_datactl_gen: directed scenarios plus random traffic against a
// deadline-based reference model (each resource tracks the edge after which it is free).
module tb_hpdmc_datactl_gen;
    localparam int unsigned NB   = 8;
    localparam int unsigned BC   = 4;
    localparam int          MAXE = 8192;

    logic sys_clk = 1'b0;
    logic sdram_rst_n;

    hpdmc_datactl_gen_if #(.NBANKS(NB)) dc ();

    hpdmc_datactl_gen #(.NBANKS(NB), .BURST_CYC(BC)) dut (
        .sys_clk     (sys_clk),
        .sdram_rst_n (sdram_rst_n),
        .dc          (dc)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int rd_until = 0;
    int wr_until = 0;
    int pc_until [NB];
    bit wr_raw [MAXE];
    bit wr_eff [MAXE];
    bit m_err = 1'b0;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // DQ is turned toward the PHY outputs from 2 to BC+3 edges after a write;
    // a write that lost to a simultaneous read only darkens the first of those.
    function automatic bit exp_dir(input int n);
        if (n >= 2 && wr_raw[n-2]) return 1'b0;
        for (int w = n - int'(BC) - 3; w <= n - 3; w++)
            if (w >= 0 && wr_eff[w]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        rd_until = 0;
        wr_until = 0;
        for (int i = 0; i < int'(NB); i++) pc_until[i] = 0;
        for (int i = 0; i < MAXE; i++) begin
            wr_raw[i] = 1'b0;
            wr_eff[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic check_all();
        logic [NB-1:0] pc_e;
        bit rs, ws, d, dr;
        rs = edge_n >= rd_until;
        ws = edge_n >= wr_until;
        for (int i = 0; i < int'(NB); i++) pc_e[i] = edge_n >= pc_until[i];
        d  = exp_dir(edge_n);
        dr = exp_dir(edge_n - 1);
        chk("read_safe", dc.read_safe, rs);
        chk("write_safe", dc.write_safe, ws);
        chk("precharge_safe", dc.precharge_safe, pc_e);
        chk("direction", dc.direction, d);
        chk("direction_r", dc.direction_r, dr);
        chk("proto_err", dc.proto_err, m_err);
        chk("idle", dc.idle, rs & ws & (&pc_e) & d);
    endtask

    // One clock edge with the given command; model updated from pre-edge state.
    task automatic step(input bit r, input bit w, input logic [NB-1:0] bank, input bit clr);
        bit rs_b, ws_b;
        dc.read           = r;
        dc.write          = w;
        dc.concerned_bank = bank;
        dc.err_clr        = clr;
        @(posedge sys_clk);
        edge_n++;
        rs_b = (edge_n - 1) >= rd_until;
        ws_b = (edge_n - 1) >= wr_until;
        if ((r && !rs_b) || (w && !ws_b) || (r && w)) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        if (r) begin
            rd_until = imax(rd_until, edge_n + int'(BC));
            wr_until = imax(wr_until, edge_n + int'(BC) + 1 + int'(dc.tim_cl));
            for (int i = 0; i < int'(NB); i++)
                if (bank[i]) pc_until[i] = imax(pc_until[i], edge_n + int'(BC));
        end else if (w) begin
            rd_until = imax(rd_until, edge_n + int'(BC) + 1 + int'(dc.tim_wtr));
            wr_until = imax(wr_until, edge_n + int'(BC));
            for (int i = 0; i < int'(NB); i++)
                if (bank[i]) pc_until[i] = imax(pc_until[i], edge_n + int'(BC) + 2 + int'(dc.tim_wr));
            if (edge_n < MAXE) wr_eff[edge_n] = 1'b1;
        end
        if (w && edge_n < MAXE) wr_raw[edge_n] = 1'b1;
        #1;
        check_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        bit r, w, c;
        logic [NB-1:0] bk;
        int k;

        sdram_rst_n       = 1'b0;
        dc.read           = 1'b0;
        dc.write          = 1'b0;
        dc.concerned_bank = '0;
        dc.err_clr        = 1'b0;
        dc.tim_cl         = 3'd3;
        dc.tim_wtr        = 2'd2;
        dc.tim_wr         = 2'd3;
        model_reset();
        #12;
        check_all();
        @(negedge sys_clk);
        sdram_rst_n = 1'b1;
        idle_steps(3);

        // Write->read turnaround: read blocked BC+1+tim_wtr = 7 cycles, write for BC = 4.
        step(1'b0, 1'b1, 8'h02, 1'b0);
        chk("wtr_rs_e0", dc.read_safe, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            chk("wtr_read_safe", dc.read_safe, i >= 7);
            chk("wtr_write_safe", dc.write_safe, i >= 4);
        end
        idle_steps(16);

        // Read->write turnaround with tim_cl=3: write blocked 8 cycles, DQ never turned.
        step(1'b1, 1'b0, 8'h01, 1'b0);
        chk("rtw_dir_e0", dc.direction, 1);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            chk("rtw_write_safe", dc.write_safe, i >= 8);
            chk("rtw_direction", dc.direction, 1);
        end
        idle_steps(16);

        // Max-preserving reload on bank 5: write L=9 at edge 0, read L=4 at edge 4.
        step(1'b0, 1'b1, 8'h20, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            if (i == 4) step(1'b1, 1'b0, 8'h20, 1'b0);
            else        step(1'b0, 1'b0, '0, 1'b0);
            chk("maxp_pc5", dc.precharge_safe[5], i >= 9);
            chk("maxp_others", dc.precharge_safe & 8'hDF, 8'hDF);
        end
        step(1'b0, 1'b0, '0, 1'b1);
        chk("maxp_errclr", dc.proto_err, 0);
        idle_steps(16);

        // Direction window: writes at edges 0 and 4 keep DQ driven after edges 2..11.
        step(1'b0, 1'b1, 8'h08, 1'b0);
        for (int i = 1; i <= 13; i++) begin
            if (i == 4) step(1'b0, 1'b1, 8'h08, 1'b0);
            else        step(1'b0, 1'b0, '0, 1'b0);
            chk("dirw_direction", dc.direction, !(i >= 2 && i <= 11));
            chk("dirw_direction_r", dc.direction_r, !(i >= 3 && i <= 12));
        end
        idle_steps(16);

        // Protocol errors.
        step(1'b1, 1'b1, 8'h01, 1'b0);
        chk("rw_both_err", dc.proto_err, 1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            chk("rw_read_wins_rs", dc.read_safe, i >= 4);
            chk("rw_read_wins_ws", dc.write_safe, i >= 8);
        end
        step(1'b0, 1'b0, '0, 1'b1);
        chk("clr_alone", dc.proto_err, 0);
        idle_steps(16);
        step(1'b1, 1'b0, 8'h01, 1'b0);
        chk("legal_read", dc.proto_err, 0);
        step(1'b1, 1'b0, 8'h01, 1'b0);
        chk("read_unsafe_err", dc.proto_err, 1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("clr_again", dc.proto_err, 0);
        step(1'b1, 1'b0, 8'h01, 1'b1);
        chk("set_beats_clr", dc.proto_err, 1);
        idle_steps(16);

        // Reset mid-burst: outputs return asynchronously, without a clock edge.
        step(1'b0, 1'b1, 8'h04, 1'b0);
        idle_steps(2);
        #2;
        sdram_rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_idle", dc.idle, 1);
        chk("arst_read_safe", dc.read_safe, 1);
        @(negedge sys_clk);
        sdram_rst_n = 1'b1;
        idle_steps(2);

        // Random traffic with varying timings, occasional violations and clears.
        for (int n = 0; n < 1500; n++) begin
            if (n % 64 == 0) begin
                dc.tim_cl  = 3'($urandom_range(0, 7));
                dc.tim_wtr = 2'($urandom_range(0, 3));
                dc.tim_wr  = 2'($urandom_range(0, 3));
            end
            k = $urandom_range(0, 99);
            r = (k < 30) || (k >= 60 && k < 62);
            w = (k >= 30 && k < 62);
            if (r && !w && edge_n < rd_until && $urandom_range(0, 9) != 0) r = 1'b0;
            if (w && !r && edge_n < wr_until && $urandom_range(0, 9) != 0) w = 1'b0;
            case ($urandom_range(0, 9))
                0:       bk = '0;
                1:       bk = NB'($urandom);
                default: bk = NB'(1) << $urandom_range(0, NB - 1);
            endcase
            c = ($urandom_range(0, 19) == 0);
            step(r, w, bk, c);
        end
        idle_steps(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
